// File: rtl/bp_update_queue.sv
`ifndef XLEN
`define XLEN 32
`endif
// bp_update_queue: buffers up to LANES branch resolutions per cycle, drains one per cycle to the predictor.
// Latency: an entry accepted at edge N appears on update_* after edge N+1; no same-cycle bypass.
// Backpressure: lanes beyond free space are flagged on resolve_drop (comb); upstream stalls on free_slots.
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int LANES = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LANES-1:0]           resolve_EN,
    input  logic [LANES*`XLEN-1:0]     resolve_pc,
    input  logic [LANES-1:0]           resolve_direction,
    input  logic [LANES*`XLEN-1:0]     resolve_target,
    output logic [LANES-1:0]           resolve_drop,
    output logic [$clog2(DEPTH+1)-1:0] free_slots,
    output logic                       update_EN,
    output logic [`XLEN-1:0]           update_pc,
    output logic                       update_direction,
    output logic [`XLEN-1:0]           update_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [`XLEN-1:0] entry_pc  [DEPTH];
    logic [`XLEN-1:0] entry_tgt [DEPTH];
    logic             entry_dir [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    space;
    logic [CW-1:0]    n_acc;
    logic [LANES-1:0] lane_acc;
    logic [PW-1:0]    lane_slot [LANES];
    logic             deq;

    // Space is judged on the pre-edge count only; the drain this cycle frees nothing yet.
    always_comb begin
        space        = CW'(DEPTH) - count;
        n_acc        = '0;
        lane_acc     = '0;
        resolve_drop = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_slot[i] = tail + n_acc[PW-1:0];
            if (resolve_EN[i]) begin
                if (n_acc < space) begin
                    lane_acc[i] = 1'b1;
                    n_acc       = n_acc + CW'(1);
                end else begin
                    resolve_drop[i] = 1'b1;
                end
            end
        end
        deq       = (count != '0);
        count_nxt = count + n_acc - {{(CW-1){1'b0}}, deq};
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_acc[i]) begin
                entry_pc[lane_slot[i]]  <= resolve_pc[i*`XLEN +: `XLEN];
                entry_tgt[lane_slot[i]] <= resolve_target[i*`XLEN +: `XLEN];
                entry_dir[lane_slot[i]] <= resolve_direction[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            free_slots       <= CW'(DEPTH);
            update_EN        <= 1'b0;
            update_pc        <= '0;
            update_direction <= 1'b0;
            update_target    <= '0;
        end else begin
            tail       <= tail + n_acc[PW-1:0];
            count      <= count_nxt;
            free_slots <= CW'(DEPTH) - count_nxt;
            update_EN  <= deq;
            // With nothing queued the update payload holds its last value.
            if (deq) begin
                head             <= head + PW'(1);
                update_pc        <= entry_pc[head];
                update_direction <= entry_dir[head];
                update_target    <= entry_tgt[head];
            end
        end
    end
endmodule
